math_sequencer: RTL and testbench
=================================

// Module: math_sequencer
// PURPOSE
//  Multi-cycle controller that sequences one shared 4-bit add/subtract datapath to run
//  ADD, SUB, MUL (shift-add) and DIV (restoring) on 4-bit unsigned operands.
//  Sits between the front-panel input logic (switch operands, start button) and the
//  display driver. Accepts one operation per start pulse; busy/done handshake.
// PARAMETERS
//  WIDTH     4   operand width; all rules below are written for WIDTH=4
//  ITERS     4   MUL/DIV iteration count; must equal WIDTH
// PORTS
//  clk     in   1  system clock, rising edge
//  rst     in   1  synchronous reset, active high
//  start   in   1  request; sampled only in IDLE
//  op      in   2  00=ADD 01=SUB 10=MUL 11=DIV; captured with start
//  a       in   4  operand A (dividend for DIV); captured with start
//  b       in   4  operand B (divisor for DIV); captured with start
//  busy    out  1  1 in EXEC and DONE states
//  done    out  1  one-cycle pulse, high in DONE state
//  result  out  8  result register; see formats below
//  flag    out  1  ADD carry / SUB borrow / DIV divide-by-zero; 0 for MUL
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, flag = 0; result = 8'h00; all internal regs cleared.
//  FSM states: IDLE -> EXEC -> DONE -> IDLE.
//   IDLE: start=1 at edge captures op,a,b; count<=0; go EXEC. Exception: op=DIV and b=0
//         -> go directly to DONE with result={a,4'hF}, flag=1.
//   EXEC: ADD/SUB: one cycle, then DONE. MUL/DIV: ITERS cycles (count 0..3), then DONE.
//   DONE: done=1 for exactly one cycle; unconditional return to IDLE.
//  Latency (start edge to done high): ADD/SUB 2 cycles; MUL/DIV 5; DIV by zero 1.
//  start while busy=1 is ignored (no queueing); op/a/b changes after capture have no effect.
//  result and flag update only on entry to DONE; held until the next DONE or rst.
//  Result formats:
//   ADD  {3'b000, carry, (a+b)[3:0]}; flag=carry.
//   SUB  {4'h0, (a-b) mod 16};       flag=borrow (a<b).
//   MUL  8-bit unsigned a*b;         flag=0.
//   DIV  {remainder[3:0], quotient[3:0]}; flag=0 when b!=0.
//  MUL algorithm: P={hi,lo}, hi=0, lo=b; each iteration: if lo[0], {c,hi}=hi+a
//   (4-bit adder, carry out c) else c=0; then {c,hi,lo} shifted right by 1.
//  DIV algorithm: R (5 bits)=0, Q=a; each iteration: {R,Q}<<=1; trial=R-{1'b0,b};
//   if no borrow R=trial, Q[0]=1 else Q[0]=0. Final R fits 4 bits.
//  All arithmetic goes through the single shared add/sub path; one add or sub per cycle.
//  Reset mid-operation: returns to IDLE next edge, outputs to reset values; no done pulse.
//  start and rst together: rst wins.
// TESTING
//  1 ADD a=9,b=8 -> done 2 cycles after start; result=8'h11, flag=1.
//  2 SUB a=3,b=5 -> result=8'h0E, flag=1; SUB a=5,b=3 -> 8'h02, flag=0.
//  3 MUL a=15,b=15 -> done exactly 5 cycles after start; result=8'hE1, flag=0;
//    MUL a=0,b=7 -> 8'h00.
//  4 DIV a=13,b=4 -> result=8'h13 (r=1,q=3), flag=0; DIV a=7,b=0 -> done after 1 cycle,
//    result=8'h7F, flag=1.
//  5 Assert start with MUL a=6,b=7, pulse start again with ADD at cycle 2 -> second
//    start ignored; result=8'h2A; busy high cycles 1-5, done single pulse.
//  6 rst asserted at cycle 3 of MUL -> next edge busy=0, done=0, result=8'h00; no done
//    pulse; a fresh ADD 1+1 afterwards gives 8'h02.

Source files
------------

// File: rtl/math_sequencer.sv
// Multi-cycle ADD/SUB/MUL/DIV sequencer around a single shared add/sub path.
// MUL is shift-add, DIV is restoring; busy/done handshake to the display side.
module math_sequencer #(
    parameter int WIDTH = 4,
    parameter int ITERS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               flag
);
    localparam int W  = WIDTH;
    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t         state_q, state_d;
    logic [1:0]     op_r;
    logic [W-1:0]   a_r, b_r;
    logic [W-1:0]   acc;
    logic [W-1:0]   qr;
    logic [CW-1:0]  count;

    logic [W+1:0]   ax, ay, asum;
    logic           asub;
    logic           last;
    logic           div0;
    logic [W:0]     mul_hc;
    logic [W-1:0]   mul_hi, mul_lo;
    logic           borrow;
    logic [W-1:0]   div_r, div_q;

    // The one adder: every operation routes its operands through here.
    assign asum = asub ? (ax - ay) : (ax + ay);

    always_comb begin
        ax   = '0;
        ay   = '0;
        asub = 1'b0;
        case (op_r)
            OP_ADD: begin
                ax = {2'b00, a_r};
                ay = {2'b00, b_r};
            end
            OP_SUB: begin
                ax   = {2'b00, a_r};
                ay   = {2'b00, b_r};
                asub = 1'b1;
            end
            OP_MUL: begin
                ax = {2'b00, acc};
                ay = {2'b00, a_r};
            end
            default: begin
                ax   = {1'b0, acc, qr[W-1]};
                ay   = {2'b00, b_r};
                asub = 1'b1;
            end
        endcase
    end

    assign last   = (count == CW'(ITERS - 1));
    assign div0   = (op == OP_DIV) && (b == '0);

    assign mul_hc = qr[0] ? asum[W:0] : {1'b0, acc};
    assign mul_hi = mul_hc[W:1];
    assign mul_lo = {mul_hc[0], qr[W-1:1]};

    // Restoring step: a borrow keeps the shifted remainder, which is < b.
    assign borrow = asum[W+1];
    assign div_r  = borrow ? ax[W-1:0] : asum[W-1:0];
    assign div_q  = {qr[W-2:0], ~borrow};

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = div0 ? DONE : EXEC;
            end
            EXEC: begin
                if (op_r == OP_ADD || op_r == OP_SUB || last)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            acc    <= '0;
            qr     <= '0;
            count  <= '0;
            result <= '0;
            flag   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        a_r   <= a;
                        b_r   <= b;
                        count <= '0;
                        acc   <= '0;
                        qr    <= (op == OP_MUL) ? b : a;
                        if (div0) begin
                            result <= {a, {W{1'b1}}};
                            flag   <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    count <= count + 1'b1;
                    case (op_r)
                        OP_ADD: begin
                            result <= {{(W-1){1'b0}}, asum[W:0]};
                            flag   <= asum[W];
                        end
                        OP_SUB: begin
                            result <= {{W{1'b0}}, asum[W-1:0]};
                            flag   <= asum[W+1];
                        end
                        OP_MUL: begin
                            acc <= mul_hi;
                            qr  <= mul_lo;
                            if (last) begin
                                result <= {mul_hi, mul_lo};
                                flag   <= 1'b0;
                            end
                        end
                        default: begin
                            acc <= div_r;
                            qr  <= div_q;
                            if (last) begin
                                result <= {div_r, div_q};
                                flag   <= 1'b0;
                            end
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_math_sequencer.sv
// Bench for math_sequencer: directed cases plus random ops against an
// arithmetic reference model (latency, result, flag, handshake).
module tb_math_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [3:0] a, b;
    logic       busy, done, flag;
    logic [7:0] result;

    int checks = 0;
    int errors = 0;

    math_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .flag(flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input int o, input int x, input int y,
                                  output int r, output int f, output int lat);
        case (o)
            0: begin r = x + y; f = (x + y > 15) ? 1 : 0; lat = 2; end
            1: begin r = (x - y + 16) % 16; f = (x < y) ? 1 : 0; lat = 2; end
            2: begin r = x * y; f = 0; lat = 5; end
            default: begin
                if (y == 0) begin r = x * 16 + 15; f = 1; lat = 1; end
                else begin r = (x % y) * 16 + x / y; f = 0; lat = 5; end
            end
        endcase
    endfunction

    task automatic run_op(input int o, input int x, input int y,
                          input string tag);
        int er, ef, el, n;
        model(o, x, y, er, ef, el);
        @(negedge clk);
        start = 1'b1; op = 2'(o); a = 4'(x); b = 4'(y);
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom); a = 4'($urandom); b = 4'($urandom);
        while (!done && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, n, el);
        chk({tag, " result"}, result, er);
        chk({tag, " flag"}, flag, ef);
        chk({tag, " busy@done"}, busy, 1);
        @(negedge clk);
        chk({tag, " done pulse"}, done, 0);
        chk({tag, " busy after"}, busy, 0);
    endtask

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset result", result, 0);
        chk("reset flag", flag, 0);
        rst = 1'b0;

        run_op(0, 9, 8, "add 9+8");
        run_op(1, 3, 5, "sub 3-5");
        run_op(1, 5, 3, "sub 5-3");
        run_op(2, 15, 15, "mul 15*15");
        run_op(2, 0, 7, "mul 0*7");
        run_op(3, 13, 4, "div 13/4");
        run_op(3, 7, 0, "div 7/0");

        // Second start while busy must be ignored.
        @(negedge clk);
        start = 1'b1; op = 2'd2; a = 4'd6; b = 4'd7;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk($sformatf("overlap busy c%0d", c), busy, (c <= 5) ? 1 : 0);
            chk($sformatf("overlap done c%0d", c), done, (c == 5) ? 1 : 0);
            if (c == 1) begin
                start = 1'b1; op = 2'd0; a = 4'd1; b = 4'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
        end
        @(negedge clk);
        chk("overlap result", result, 8'h2A);
        chk("overlap flag", flag, 0);

        // Reset during MUL, third cycle.
        start = 1'b1; op = 2'd2; a = 4'd15; b = 4'd15;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst result", result, 0);
        chk("midrst flag", flag, 0);
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("midrst no done", seen, 0);
        run_op(0, 1, 1, "add after rst");

        // start together with rst: rst wins.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; op = 2'd0; a = 4'd2; b = 4'd2;
        @(posedge clk);
        @(negedge clk);
        chk("rst+start busy", busy, 0);
        chk("rst+start result", result, 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst+start idle", busy, 0);

        for (int i = 0; i < 40; i++) begin
            int ro, rx, ry;
            ro = $urandom_range(0, 3);
            rx = $urandom_range(0, 15);
            ry = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 15);
            run_op(ro, rx, ry, $sformatf("rand%0d op%0d %0d,%0d", i, ro, rx, ry));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
